// File: rtl/param_updown_counter_pkg.sv
// Shared mode constants, edge-action encoding and width helpers for the
// parametrised up/down counter.
`default_nettype none

package param_updown_counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // What the count register does at the next edge, after Clr has been excluded.
  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_STEP = 2'd2
  } cnt_action_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Phase register needs at least one bit even when the prescaler is trivial.
  function automatic int phase_width(input int prescale);
    return (clog2(prescale) < 1) ? 1 : clog2(prescale);
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_updown_counter_prescale_tick.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
`default_nettype none

module param_updown_counter_prescale_tick
  import param_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic Clk,
  input  logic Clr,
  input  logic En,
  input  logic Rst_phase,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_passthru
      logic unused_inputs;
      assign unused_inputs = ^{Clk, Clr, Rst_phase};
      assign tick = En;
    end else begin : g_phase
      localparam int PW = phase_width(PRESCALE);
      localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      // Phase only advances on enabled cycles, so gaps in En stretch the period.
      always_ff @(posedge Clk) begin
        if (Clr || Rst_phase) begin
          phase <= '0;
        end else if (En) begin
          phase <= (phase == LAST_PHASE) ? '0 : phase + PW'(1);
        end
      end

      assign tick = En && (phase == LAST_PHASE);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down event counter with modulus, wrap/saturate,
// parallel load, enable prescaler and terminal-count outputs for cascading.
`default_nettype none

module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] count,
  output logic             Tc,
  output logic             AtTerm
);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $fatal(1, "param_updown_counter: WIDTH=%0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $fatal(1, "param_updown_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $fatal(1, "param_updown_counter: PRESCALE=%0d outside 1..256", PRESCALE);
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
      $fatal(1, "param_updown_counter: SATURATE=%0d must be 0 or 1", SATURATE);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  cnt_action_e      action;

  // Load restarts the prescaler phase; any tick in the load cycle is discarded.
  param_updown_counter_prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .Clk       (Clk),
    .Clr       (Clr),
    .En        (En),
    .Rst_phase (Load),
    .tick      (tick)
  );

  assign at_term      = Up ? (count == MAX_CNT) : (count == '0);
  assign AtTerm       = at_term;
  assign load_clamped = (LoadVal > MAX_CNT) ? MAX_CNT : LoadVal;

  always_comb begin
    action = ACT_IDLE;
    if (Load) begin
      action = ACT_LOAD;
    end else if (tick) begin
      action = ACT_STEP;
    end
  end

  // Wrap is by explicit compare so non-power-of-2 moduli never leave 0..MODULUS-1.
  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    case (action)
      ACT_LOAD: count_next = load_clamped;
      ACT_STEP: begin
        if (at_term) begin
          tc_next = 1'b1;
          if (SATURATE == CNT_WRAP) begin
            count_next = Up ? '0 : MAX_CNT;
          end
        end else begin
          count_next = Up ? count + WIDTH'(1) : count - WIDTH'(1);
        end
      end
      default: count_next = count;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      count <= '0;
      Tc    <= 1'b0;
    end else begin
      count <= count_next;
      Tc    <= tc_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: four counter configurations on shared stimulus,
// a reference model feeding a scoreboard, a vector table and corner sequences.
`default_nettype none

module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       clr, en, up, load;
  logic [3:0] lv;

  logic [2:0] c0, c2;
  logic [3:0] c1, c3;
  logic       t0, t1, t2, t3;
  logic       a0, a1, a2, a3;

  always #10 clk = ~clk;

  // d0: defaults; d1: mod 10; d2: saturating; d3: mod 10 with prescale 4
  param_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .PRESCALE(1)) u_d0 (
    .Clk(clk), .Clr(clr), .En(en), .Up(up), .Load(load), .LoadVal(lv[2:0]),
    .count(c0), .Tc(t0), .AtTerm(a0));
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_d1 (
    .Clk(clk), .Clr(clr), .En(en), .Up(up), .Load(load), .LoadVal(lv),
    .count(c1), .Tc(t1), .AtTerm(a1));
  param_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1), .PRESCALE(1)) u_d2 (
    .Clk(clk), .Clr(clr), .En(en), .Up(up), .Load(load), .LoadVal(lv[2:0]),
    .count(c2), .Tc(t2), .AtTerm(a2));
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(4)) u_d3 (
    .Clk(clk), .Clr(clr), .En(en), .Up(up), .Load(load), .LoadVal(lv),
    .count(c3), .Tc(t3), .AtTerm(a3));

  int cfg_w[4] = '{3, 4, 3, 4};
  int cfg_m[4] = '{8, 10, 8, 10};
  int cfg_s[4] = '{0, 0, 1, 0};
  int cfg_p[4] = '{1, 1, 1, 4};

  int   m_cnt[4];
  int   m_ph[4];
  logic m_tc[4];

  typedef struct {
    int         dut;
    logic [3:0] cnt;
    logic       tc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       clr, en, up, load;
    logic [3:0] lv;
    int         cnt;
    logic       tc;
  } vec_t;
  vec_t tbl[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [3:0] get_cnt(input int i);
    case (i)
      0: return {1'b0, c0};
      1: return c1;
      2: return {1'b0, c2};
      default: return c3;
    endcase
  endfunction

  function automatic logic get_tc(input int i);
    case (i)
      0: return t0;
      1: return t1;
      2: return t2;
      default: return t3;
    endcase
  endfunction

  function automatic logic get_at(input int i);
    case (i)
      0: return a0;
      1: return a1;
      2: return a2;
      default: return a3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    int  mx;
    int  v;
    bit  tick;
    mx = cfg_m[i] - 1;
    v  = int'(lv) & ((1 << cfg_w[i]) - 1);
    if (clr) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 1'b0;
    end else if (load) begin
      m_cnt[i] = (v > mx) ? mx : v; m_ph[i] = 0; m_tc[i] = 1'b0;
    end else begin
      tick = en && (m_ph[i] == cfg_p[i] - 1);
      if (en) m_ph[i] = tick ? 0 : m_ph[i] + 1;
      m_tc[i] = 1'b0;
      if (tick) begin
        if (up) begin
          if (m_cnt[i] == mx) begin
            m_tc[i] = 1'b1;
            if (cfg_s[i] == 0) m_cnt[i] = 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            m_tc[i] = 1'b1;
            if (cfg_s[i] == 0) m_cnt[i] = mx;
          end else m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, predict every DUT, then compare after the edge.
  task automatic drive(input logic c, input logic e, input logic u, input logic l,
                       input logic [3:0] v);
    clr = c; en = e; up = u; load = l; lv = v;
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      model_step(i);
      x.dut = i; x.cnt = 4'(m_cnt[i]); x.tc = m_tc[i];
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t x;
      logic at_exp;
      x = exp_q.pop_front();
      at_exp = up ? (int'(x.cnt) == cfg_m[x.dut] - 1) : (x.cnt == 4'd0);
      check($sformatf("sb_count_d%0d", x.dut), get_cnt(x.dut), x.cnt);
      check($sformatf("sb_tc_d%0d", x.dut), get_tc(x.dut), x.tc);
      check($sformatf("sb_atterm_d%0d", x.dut), get_at(x.dut), at_exp);
    end
  endtask

  function automatic vec_t mk(input logic c, e, u, l, input logic [3:0] v,
                              input int cnt, input logic tc);
    vec_t r;
    r.clr = c; r.en = e; r.up = u; r.load = l; r.lv = v; r.cnt = cnt; r.tc = tc;
    return r;
  endfunction

  initial begin
    clr = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; lv = 4'd0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 1'b0;
    end

    // Expected values for the default configuration, derived by hand.
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(0, 1, 1, 0, 0, k, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 7, 1));
    tbl.push_back(mk(0, 1, 1, 1, 5, 5, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 5, 0));
    tbl.push_back(mk(1, 1, 1, 1, 6, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 12, 4, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].clr, tbl[k].en, tbl[k].up, tbl[k].load, tbl[k].lv);
      check($sformatf("tbl_count_%0d", k), {1'b0, c0}, 4'(tbl[k].cnt));
      check($sformatf("tbl_tc_%0d", k), t0, tbl[k].tc);
    end

    // Mod-10 down count from 0 wraps to 9.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("mod10_down_wrap", c1, 4'd9);
    check("mod10_down_wrap_tc", t1, 1'b1);
    drive(0, 1, 0, 0, 0);
    check("mod10_down_8", c1, 4'd8);
    check("mod10_down_8_tc", t1, 1'b0);
    drive(0, 1, 0, 0, 0);
    check("mod10_down_7", c1, 4'd7);

    // Saturation at the top bound, then step down.
    drive(0, 0, 1, 1, 7);
    check("sat_load7", c2, 3'd7);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      check("sat_hold", c2, 3'd7);
      check("sat_hold_tc", t2, 1'b1);
    end
    drive(0, 1, 0, 0, 0);
    check("sat_down", c2, 3'd6);
    check("sat_down_tc", t2, 1'b0);

    // Load clamp and priorities.
    drive(0, 0, 1, 1, 12);
    check("load_clamp", c1, 4'd9);
    drive(1, 0, 1, 1, 5);
    check("clr_over_load", c1, 4'd0);
    drive(0, 1, 1, 1, 3);
    check("load_over_step", c1, 4'd3);
    check("load_over_step_tc", t1, 1'b0);

    // Prescale 4: steps every 4th enabled edge; gaps in En stretch the period.
    drive(1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      check("pre_wait", c3, 4'd0);
    end
    drive(0, 1, 1, 0, 0);
    check("pre_step1", c3, 4'd1);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0);
      check("pre_gap", c3, 4'd1);
    end
    drive(0, 1, 1, 0, 0);
    check("pre_after_gap_1", c3, 4'd1);
    drive(0, 1, 1, 0, 0);
    check("pre_after_gap_2", c3, 4'd2);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 5);
    check("pre_load", c3, 4'd5);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      check("pre_load_wait", c3, 4'd5);
    end
    drive(0, 1, 1, 0, 0);
    check("pre_load_step", c3, 4'd6);

    // Random traffic, checked against the model through the scoreboard.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            ((k / 23) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
